fetch_decode_queue: RTL

- Parametrised instruction buffer between the fetch and decode stages.
- Replaces the single fe_inst/fe_pc register with a DEPTH-entry FIFO.
- Uses a valid/ready handshake on both sides.
- Predecodes a class vector for each entry at push time.
- Supports a branch flush that can preserve the MIPS delay-slot instruction.

---
 rtl/fetch_decode_queue_if.sv | 32 +++
 rtl/fetch_decode_queue.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode queue bus: fetch-side push handshake, decode-side head and
// pop handshake, flush controls and occupancy.
interface fetch_decode_queue_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic [5:0]        out_class;
  logic              flush;
  logic              flush_keep;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_pc, in_inst, out_ready, flush, flush_keep,
    input  in_ready, out_valid, out_pc, out_inst, out_class, count
  );

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready, flush, flush_keep,
    output in_ready, out_valid, out_pc, out_inst, out_class, count
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// DEPTH-entry fetch->decode instruction FIFO with push-time predecode and
// delay-slot-preserving flush. Optional same-cycle bypass: FETCH_DECODE_QUEUE_BYPASS_EN.
module fetch_decode_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_decode_queue_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned CLS_W = 6;

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [CLS_W-1:0]  cls_mem  [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [CNT_W-1:0] count_q, count_nxt, remain;
  logic             empty, full, in_ready_c, push, pop_mem, bypass_take, write;
  logic [CLS_W-1:0] in_cls;

  logic              out_valid_c;
  logic [PC_W-1:0]   out_pc_c;
  logic [INST_W-1:0] out_inst_c;
  logic [CLS_W-1:0]  out_class_c;

  // Class bits: [0] branch, [1] j/jal, [2] jr/jalr, [3] mul/div, [4] lw, [5] sw.
  function automatic logic [CLS_W-1:0] predecode(input logic [5:0] op,
                                                 input logic [4:0] rt,
                                                 input logic [5:0] fn);
    logic [CLS_W-1:0] c;
    c    = '0;
    c[0] = (op[5:2] == 4'b0001) | ((op == 6'b000001) & (rt[3:1] == 3'b000));
    c[1] = (op[5:1] == 5'b00001);
    c[2] = (op == 6'b000000) & (fn[5:1] == 5'b00100);
    c[3] = (op == 6'b000000) & (fn[5:2] == 4'b0110);
    c[4] = (op == 6'b100011);
    c[5] = (op == 6'b101011);
    return c;
  endfunction

  assign in_cls     = predecode(bus.in_inst[31:26], bus.in_inst[20:16], bus.in_inst[5:0]);
  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign in_ready_c = ~reset & ~bus.flush & ~full;
  assign push       = bus.in_valid & in_ready_c;
  assign pop_mem    = ~empty & bus.out_ready;

`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
  // Empty queue with a consumer ready: the instruction never touches storage.
  assign bypass_take = empty & push & bus.out_ready;
`else
  assign bypass_take = 1'b0;
`endif

  assign write      = push & ~bypass_take;
  assign remain     = count_q - CNT_W'(pop_mem);
  assign rd_ptr_nxt = rd_ptr + PTR_W'(pop_mem);

  // Occupancy and write pointer; flush rebuilds them around the post-pop head.
  always_comb begin
    count_nxt  = remain + CNT_W'(write);
    wr_ptr_nxt = wr_ptr + PTR_W'(write);
    if (bus.flush) begin
      if (bus.flush_keep && (remain != '0)) begin
        count_nxt  = CNT_W'(1);
        wr_ptr_nxt = rd_ptr_nxt + PTR_W'(1);
      end else begin
        count_nxt  = '0;
        wr_ptr_nxt = rd_ptr_nxt;
      end
    end
  end

  always_comb begin
    out_valid_c = ~empty;
    out_pc_c    = pc_mem[rd_ptr];
    out_inst_c  = inst_mem[rd_ptr];
    out_class_c = cls_mem[rd_ptr];
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
    if (empty && push) begin
      out_valid_c = 1'b1;
      out_pc_c    = bus.in_pc;
      out_inst_c  = bus.in_inst;
      out_class_c = in_cls;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
        cls_mem[i]  <= '0;
      end
    end else begin
      count_q <= count_nxt;
      rd_ptr  <= rd_ptr_nxt;
      wr_ptr  <= wr_ptr_nxt;
      if (write) begin
        pc_mem[wr_ptr]   <= bus.in_pc;
        inst_mem[wr_ptr] <= bus.in_inst;
        cls_mem[wr_ptr]  <= in_cls;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_pc    = out_pc_c;
  assign bus.out_inst  = out_inst_c;
  assign bus.out_class = out_class_c;
  assign bus.count     = count_q;
endmodule
